win_checker: RTL
================

# win_checker

Parametrised five-in-a-row detector for the OMOK datapath. It sits beside `wood_board` and is started by the same `put` event. On each start it takes a snapshot of `board_state` and walks the four line directions through the placed stone, one cell per clock. It reports win/no-win, the winning direction and the run length, and holds a sticky `game_over` flag. Board size, win length and exact-length (overline-rejecting) mode are parameters.

## Interface
- BOARD_N, 10, board dimension; cells indexed row*BOARD_N+col
- WIN_LEN, 5, run length that wins
- EXACT_MODE, 0, 0: run >= WIN_LEN wins; 1: run == WIN_LEN only (overlines lose)
- POS_W, 8, width of `pos`
- LEN_W, 5, width of `run_len`; must satisfy 2^LEN_W > 2*BOARD_N-1

Ports:
- clk  input  1  single system clock, all logic on posedge
- rst  input  1  synchronous, active-low reset
- start  input  1  request check; sampled only in IDLE
- pos  input  POS_W  linear index of the placed stone
- color  input  2  player code of the placed stone (2'b10 black, 2'b11 white)
- board_state  input  BOARD_N*BOARD_N*2  2 bits per cell, cell k at [2k+:2]
- busy  output  1  high while a check is in progress
- done  output  1  one-cycle pulse; results valid from this cycle onward
- win  output  1  result of the last check
- win_dir  output  2  0 horizontal, 1 vertical, 2 diagonal \ (+BOARD_N+1), 3 diagonal / (+BOARD_N-1)
- run_len  output  LEN_W  length of the winning run; if no win, the maximum run over all directions
- game_over  output  1  sticky; set with the first done that has win=1

## Operation
- While rst=0 at a posedge, every output and all state clear to 0 and the FSM goes to IDLE. This holds mid-scan too; the check in progress is abandoned and no done is produced.
- IDLE: if start=1, busy=0 and game_over=0, latch pos, color and a snapshot of board_state, and compute row/col.
  - start is ignored while busy=1 or game_over=1. No done is produced for an ignored start.
- Invalid position: if pos >= BOARD_N*BOARD_N, go to DONE directly with win=0, run_len=0, win_dir=0.
- Placed cell: the cell at pos is always treated as `color`, regardless of its snapshot content. `wood_board` writes the cell on the same edge, so the snapshot may still show it empty.
- Per direction d = 0..3:
  - SCAN_P steps from pos in the + direction.
  - SCAN_N then steps from pos in the − direction.
- Each scan cycle examines one neighbour cell:
  - Match (in-board and equal to color): counter increments and the walk continues.
  - Mismatch, or leaving the board: the walk ends and the FSM moves on.
  - A row or column wrap counts as leaving the board. Horizontal stays in the same row; diagonals stop at column 0 or column BOARD_N-1.
- EVAL: len = 1 + p + n. Then:
  - win_cond = (len >= WIN_LEN), or (len == WIN_LEN) when EXACT_MODE=1.
  - If win_cond, record d and len, and go to DONE.
  - Otherwise update the running maximum and go to the next d. After d=3, go to DONE with win=0.
- DONE (1 cycle): pulse done, drive the results, set game_over if win, return to IDLE.
- win, win_dir and run_len hold their values until the next accepted start, which clears them and raises busy.

## Timing
- start is sampled at edge T. busy=1 from T+1 until the edge at which done rises; busy and done are never high together.
- Scan cost:
  - Each SCAN phase takes (matches+1) cycles, including the terminating cycle.
  - A walk that starts at the board edge costs 1 cycle.
  - EVAL costs 1 cycle.
- Latency: done is high in the cycle after edge T+L, where L = 1 + Σ over evaluated directions of (p+1)+(n+1)+1.
  - A winning direction stops evaluation; later directions are not scanned.
- Invalid pos: L = 1.
- rst=0 has priority over start on the same edge.

## Test plan
- Lone stone: empty board, pos=44, color=11, start at T → done at T+13, win=0, run_len=1, win_dir=0, game_over=0.
- Horizontal five: cells 40..44 are 11 (42 placed), start pos=42 → done at T+8, win=1, win_dir=0, run_len=5, game_over=1. A following start gives no done and busy stays 0.
- Diagonal \ from the corner: cells 0,11,22,33,44 are 11, start pos=0 → done at T+14, win=1, win_dir=2, run_len=5.
- Overline with EXACT_MODE=1: cells 40..45 are 10, start pos=42 → done at T+18, win=0, run_len=6, game_over=0. Same case with EXACT_MODE=0 → done at T+9, win=1, run_len=6.
- Row-wrap guard: cells 37,38,39 and 40,41 are 11, start pos=39 → no horizontal win; run_len=3, win=0.
- Busy/reset: a second start at T+3 during a scan is ignored (exactly one done). rst=0 at T+4 → busy, done, win and game_over are all 0 at T+5, and no done pulse follows.

Source files
------------

// File: rtl/win_checker.sv
// win_checker: five-in-a-row detector that walks the four line directions
// through the placed stone, one neighbour cell per clock.
module win_checker #(
  parameter int BOARD_N    = 10,
  parameter int WIN_LEN    = 5,
  parameter int EXACT_MODE = 0,
  parameter int POS_W      = 8,
  parameter int LEN_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [POS_W-1:0]             pos,
  input  logic [1:0]                   color,
  input  logic [BOARD_N*BOARD_N*2-1:0] board_state,
  output logic                         busy,
  output logic                         done,
  output logic                         win,
  output logic [1:0]                   win_dir,
  output logic [LEN_W-1:0]             run_len,
  output logic                         game_over
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int RC_W  = $clog2(BOARD_N);
  localparam int SW    = $clog2(2 * CELLS);
  typedef enum logic [2:0] {IDLE, INIT, SCAN_P, SCAN_N, EVAL, DONE} state_t;
  state_t state, state_nx;
  logic [POS_W-1:0] pos_q;
  logic [1:0] color_q, dir;
  logic [2*CELLS-1:0] snap;
  logic [RC_W-1:0] r0, c0, cr, cc;
  logic [LEN_W-1:0] p_cnt, n_cnt, len;
  logic [SW-1:0] boff;
  logic invalid, in_board, match, win_cond, accept;
  int sg, nr, nc;
  // Neighbour of the cursor along the current direction; the - walk negates the step.
  always_comb begin
    sg = (state == SCAN_N) ? -1 : 1;
    nr = int'(cr) + sg * ((dir == 2'd0) ? 0 : 1);
    nc = int'(cc) + sg * ((dir == 2'd1) ? 0 : (dir == 2'd3) ? -1 : 1);
    in_board = nr >= 0 && nr < BOARD_N && nc >= 0 && nc < BOARD_N;
    boff = SW'(2 * (nr * BOARD_N + nc));
    match = in_board && snap[boff +: 2] == color_q;
  end
  assign len      = LEN_W'(1) + p_cnt + n_cnt;
  assign invalid  = int'(pos_q) >= CELLS;
  assign win_cond = (EXACT_MODE != 0) ? int'(len) == WIN_LEN : int'(len) >= WIN_LEN;
  assign accept   = start && !game_over;
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? INIT : IDLE;
      INIT:    state_nx = invalid ? DONE : SCAN_P;
      SCAN_P:  state_nx = match ? SCAN_P : SCAN_N;
      SCAN_N:  state_nx = match ? SCAN_N : EVAL;
      EVAL:    state_nx = (win_cond || dir == 2'd3) ? DONE : SCAN_P;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q     <= '0;
      color_q   <= '0;
      snap      <= '0;
      r0        <= '0;
      c0        <= '0;
      cr        <= '0;
      cc        <= '0;
      dir       <= '0;
      p_cnt     <= '0;
      n_cnt     <= '0;
      win       <= 1'b0;
      win_dir   <= '0;
      run_len   <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          pos_q   <= pos;
          color_q <= color;
          snap    <= board_state;
          win     <= 1'b0;
          win_dir <= '0;
          run_len <= '0;
        end
        INIT: begin
          r0    <= RC_W'(int'(pos_q) / BOARD_N);
          c0    <= RC_W'(int'(pos_q) % BOARD_N);
          cr    <= RC_W'(int'(pos_q) / BOARD_N);
          cc    <= RC_W'(int'(pos_q) % BOARD_N);
          dir   <= '0;
          p_cnt <= '0;
          n_cnt <= '0;
        end
        SCAN_P: if (match) begin
          p_cnt <= p_cnt + 1'b1;
          cr    <= RC_W'(nr);
          cc    <= RC_W'(nc);
        end else begin
          cr <= r0;
          cc <= c0;
        end
        SCAN_N: if (match) begin
          n_cnt <= n_cnt + 1'b1;
          cr    <= RC_W'(nr);
          cc    <= RC_W'(nc);
        end
        // run_len tracks the best run so far; a win overwrites it with the winning length
        EVAL: begin
          if (win_cond) begin
            win     <= 1'b1;
            win_dir <= dir;
            run_len <= len;
          end else if (len > run_len)
            run_len <= len;
          dir   <= dir + 1'b1;
          p_cnt <= '0;
          n_cnt <= '0;
          cr    <= r0;
          cc    <= c0;
        end
        DONE: game_over <= game_over | win;
        default: ;
      endcase
    end
  end
endmodule
